// File: rtl/regfile_dump.sv
// regfile_dump: sequential read-side sweeper for the register file.
// On a start pulse it walks an inclusive address range [first_addr, last_addr]
// through one regfile read port and streams each value out on a valid/ready
// interface, tagged with its register number. It owns the read port while busy.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle dump request, sampled only in IDLE
//   first_addr  first register to dump (sampled with start)
//   last_addr   last register to dump, inclusive (sampled with start)
//   ra          address driven to the regfile read port
//   rd          regfile read data, combinational from ra
//   m_valid     output beat valid
//   m_ready     sink accepts beat
//   m_data      register value
//   m_addr      register number of m_data
//   m_last      beat is the last of the dump
//   busy        dump in progress
//   done        one-cycle pulse after the final beat is accepted
//   err         one-cycle pulse when a start is rejected (first_addr > last_addr)
module regfile_dump #(
    parameter int N_ADDR_W = 5,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_ADDR_W-1:0] first_addr,
    input  logic [N_ADDR_W-1:0] last_addr,
    output logic [N_ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0]   rd,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic [N_ADDR_W-1:0] m_addr,
    output logic                m_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [N_ADDR_W-1:0] cur_r, cur_s;
    logic [N_ADDR_W-1:0] last_q_r, last_q_s;
    logic [N_ADDR_W-1:0] ra_r, ra_s;
    logic                m_valid_r, m_valid_s;
    logic [DATA_W-1:0]   m_data_r, m_data_s;
    logic [N_ADDR_W-1:0] m_addr_r, m_addr_s;
    logic                m_last_r, m_last_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                err_r, err_s;

    logic                range_ok_s;
    logic [N_ADDR_W-1:0] cur_inc_s;

    assign range_ok_s = (first_addr <= last_addr);
    // cur never passes last_q, so this increment cannot wrap in practice.
    assign cur_inc_s  = cur_r + N_ADDR_W'(1);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && range_ok_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (m_last_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and (registered) outputs per state
    always_comb begin
        cur_s     = cur_r;
        last_q_s  = last_q_r;
        ra_s      = ra_r;
        m_valid_s = m_valid_r;
        m_data_s  = m_data_r;
        m_addr_s  = m_addr_r;
        m_last_s  = m_last_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (range_ok_s) begin
                        cur_s    = first_addr;
                        ra_s     = first_addr;
                        last_q_s = last_addr;
                        busy_s   = 1'b1;
                    end else begin
                        err_s    = 1'b1;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_FETCH: begin
                // rd reflects ra during this cycle: no snapshot of the file.
                m_data_s  = rd;
                m_addr_s  = cur_r;
                m_last_s  = (cur_r == last_q_r);
                m_valid_s = 1'b1;
            end
            ST_SEND: begin
                if (m_ready) begin
                    m_valid_s = 1'b0;
                    if (m_last_r) begin
                        m_last_s = 1'b0;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        cur_s = cur_inc_s;
                        ra_s  = cur_inc_s;
                    end
                end else begin
                    m_valid_s = m_valid_r;
                end
            end
            default: begin
                m_valid_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_r     <= {N_ADDR_W{1'b0}};
            last_q_r  <= {N_ADDR_W{1'b0}};
            ra_r      <= {N_ADDR_W{1'b0}};
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
            m_addr_r  <= {N_ADDR_W{1'b0}};
            m_last_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            cur_r     <= cur_s;
            last_q_r  <= last_q_s;
            ra_r      <= ra_s;
            m_valid_r <= m_valid_s;
            m_data_r  <= m_data_s;
            m_addr_r  <= m_addr_s;
            m_last_r  <= m_last_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign ra      = ra_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_addr  = m_addr_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected beats,
// a negedge monitor pops and compares whenever the DUT presents a beat.
module tb_regfile_dump;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [4:0]  m_addr;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int cyc;
    int stall_cfg;
    int stall_cnt;
    logic prev_v;

    logic [63:0] regs [32];
    logic [69:0] exp_q [$];

    regfile_dump #(.N_ADDR_W(5), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .ra(ra), .rd(rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_addr(m_addr), .m_last(m_last),
        .busy(busy), .done(done), .err(err)
    );

    // Regfile model: combinational read, XZR reads as zero
    assign rd = (ra == 5'd31) ? 64'd0 : regs[ra];

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Sink: either always ready, or stall stall_cfg cycles after each m_valid rise
    initial begin
        stall_cnt = 0;
        prev_v    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cfg == 0) begin
                m_ready = 1'b1;
                stall_cnt = 0;
            end else begin
                if (m_valid && !prev_v) stall_cnt = stall_cfg;
                if (stall_cnt > 0) begin
                    m_ready = 1'b0;
                    stall_cnt--;
                end else begin
                    m_ready = 1'b1;
                end
            end
            prev_v = m_valid;
        end
    end

    // Monitor: compare every presented beat to the scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (reset && m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_addr", {123'd0, m_addr}, 128'hFFFF);
            end else begin
                check("beat", {58'd0, m_addr, m_data, m_last}, {58'd0, exp_q[0]});
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            logic [4:0]  a;
            logic [63:0] d;
            a = i[4:0];
            d = (i == 31) ? 64'd0 : regs[i];
            exp_q.push_back({a, d, (i == l) ? 1'b1 : 1'b0});
        end
    endtask

    // Pulse start for one cycle; returns counter value just after the start edge
    task automatic do_start(input logic [4:0] f, input logic [4:0] l, output int ce);
        @(posedge clk);
        #1;
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(posedge clk);
        #1;
        ce = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int ce, input int exp_delta);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check({nm, "_done_seen"}, {127'd0, found}, 128'd1);
        if (found) begin
            if (exp_delta >= 0) check({nm, "_done_cycle"}, 128'(cyc - ce), 128'(exp_delta));
            check({nm, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
            @(negedge clk);
            check({nm, "_done_single"}, {127'd0, done}, 128'd0);
            check({nm, "_busy_after"}, {127'd0, busy}, 128'd0);
        end
    endtask

    initial begin
        int ce;
        logic found;
        int done_cnt;
        checks = 0;
        errors = 0;
        cyc = 0;
        stall_cfg = 0;
        m_ready = 1'b1;
        start = 1'b0;
        first_addr = 5'd0;
        last_addr = 5'd0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 31) ? 64'd0 : 64'(i);

        // Reset with random inputs: all outputs zero
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            start = 1'($urandom);
            first_addr = 5'($urandom);
            last_addr = 5'($urandom);
            #7;
            check("reset_outputs", {49'd0, ra, m_valid, m_data, m_addr, m_last, busy, done, err}, 128'd0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_outputs", {49'd0, ra, m_valid, m_data, m_addr, m_last, busy, done, err}, 128'd0);

        // Full dump 0..31 at full throughput
        push_range(0, 31);
        do_start(5'd0, 5'd31, ce);
        check("full_busy", {127'd0, busy}, 128'd1);
        check("full_ra", {123'd0, ra}, 128'd0);
        wait_done("full", ce, 64);

        // Backpressure on 3..5
        regs[3] = 64'hA3;
        regs[4] = 64'hA4;
        regs[5] = 64'hA5;
        stall_cfg = 3;
        push_range(3, 5);
        do_start(5'd3, 5'd5, ce);
        wait_done("bp", ce, 2 * 3 + 3 * 3);
        stall_cfg = 0;

        // Single register
        regs[7] = 64'h0123_4567_89AB_CDEF;
        push_range(7, 7);
        do_start(5'd7, 5'd7, ce);
        wait_done("single", ce, 2);

        // Rejected start
        do_start(5'd9, 5'd2, ce);
        check("err_pulse", {125'd0, err, busy, m_valid}, 128'h4);
        @(posedge clk);
        #1;
        check("err_single", {125'd0, err, busy, m_valid}, 128'd0);

        // Start while busy is ignored
        push_range(10, 12);
        do_start(5'd10, 5'd12, ce);
        @(posedge clk);
        #1;
        start = 1'b1;
        first_addr = 5'd0;
        last_addr = 5'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_no_err", {127'd0, err}, 128'd0);
        wait_done("busy_start", ce, 6);

        // Reset during SEND of beat 4 of dump 0..8
        stall_cfg = 3;
        push_range(0, 8);
        do_start(5'd0, 5'd8, ce);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (m_valid && m_addr == 5'd4) found = 1'b1;
        end
        check("mid_reach_beat4", {127'd0, found}, 128'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_drop", {126'd0, m_valid, busy}, 128'd0);
        exp_q.delete();
        stall_cfg = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_no_done", 128'(done_cnt), 128'd0);
        push_range(0, 1);
        do_start(5'd0, 5'd1, ce);
        wait_done("after_reset", ce, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-side sweeper for the 32×64 register file. On a start pulse it walks a contiguous address range through one regfile read port and streams each value out over a valid/ready interface, tagged with its register number. It sits beside decode as a debug/dump path and owns that read port while busy. XZR (address 31) is streamed as whatever the regfile returns, which is 0.

## Interface
- N_ADDR_W, default 5: register address width.
- DATA_W, default 64: register data width.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  in  N_ADDR_W  first register to dump; sampled with start.
- last_addr  in  N_ADDR_W  last register to dump, inclusive; sampled with start.
- ra  out  N_ADDR_W  address driven to regfile read port.
- rd  in  DATA_W  regfile read data, combinational from ra.
- m_valid  out  1  output beat valid.
- m_ready  in  1  sink accepts beat.
- m_data  out  DATA_W  register value.
- m_addr  out  N_ADDR_W  register number of m_data.
- m_last  out  1  beat is last of the dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after final beat accepted.
- err  out  1  one-cycle pulse: start rejected (first_addr > last_addr).

## Operation
- States: IDLE, FETCH, SEND.
- Internal: cur (N_ADDR_W), last_q (N_ADDR_W).
- IDLE, start=1, first_addr <= last_addr: cur<=first_addr, ra<=first_addr, last_q<=last_addr, busy<=1 -> FETCH.
- IDLE, start=1, first_addr > last_addr: err<=1 for one cycle, stay IDLE, busy stays 0.
- start while busy: ignored, no error.
- FETCH (exactly one cycle): m_data<=rd, m_addr<=cur, m_last<=(cur==last_q), m_valid<=1 -> SEND.
- SEND, m_ready=0: m_valid, m_data, m_addr, m_last held stable.
- SEND, m_ready=1, m_last=0: m_valid<=0, cur<=cur+1, ra<=cur+1 -> FETCH.
- SEND, m_ready=1, m_last=1: m_valid<=0, m_last<=0, busy<=0, done<=1 for one cycle -> IDLE.
- ra holds its last value in IDLE.
- Address arithmetic is N_ADDR_W-bit unsigned. cur never increments past last_q, so no wrap occurs, including last_addr=31.
- Not a snapshot: each value is rd as seen during that register's FETCH cycle. Regfile writes to registers not yet fetched are visible in the dump.

## Timing
- Reset (reset=0) values, asynchronous: state=IDLE, ra=0, m_valid=0, m_data=0, m_addr=0, m_last=0, busy=0, done=0, err=0, cur=0, last_q=0.
- Reset mid-dump: m_valid and busy drop immediately. The partial dump is abandoned with no done pulse.
- start sampled at edge e: busy=1 and ra=first after e; m_valid=1 after e+1.
- One beat per 2 cycles at full throughput (FETCH + SEND).
- m_ready held 1, dumping N registers: beat k handshakes at edge e+2+2k; done=1 during the cycle after edge e+2N.
- Each backpressure cycle adds exactly one cycle.
- done and err are single-cycle registered pulses.
- m_valid is never deasserted without a handshake except by reset.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, idle 5 cycles -> outputs unchanged, busy=0.
- Full dump: regfile Xi=i for i=0..30; start with first=0, last=31, m_ready=1 -> 32 beats with m_addr=i and m_data=i for i<31. Beat 31: m_data=0, m_last=1. done pulses in cycle 64 after start edge; busy=0 afterwards.
- Backpressure: X3..X5 = 0xA3, 0xA4, 0xA5; first=3, last=5; m_ready=0 for 3 cycles after each m_valid rise -> m_data/m_addr stable while stalled; exactly 3 beats (3/0xA3, 4/0xA4, 5/0xA5 with m_last); done after beat 5.
- Single and error: first=last=7 -> one beat, m_addr=7, m_last=1. first=9, last=2 -> err=1 for one cycle, m_valid stays 0, busy stays 0.
- Start while busy: pulse start with first=0 during dump 10..12 -> only beats 10, 11, 12 appear.
- Reset mid-dump: assert reset during SEND of beat 4 of dump 0..8 -> m_valid=0 immediately, no done. After release, start first=0, last=1 -> beats 0, 1 and a normal done.
